// File: rtl/quiz_pkg.sv
// rtl/quiz_pkg.sv - shared types and constants for the quiz round sequencer
//
// Purpose: state encoding, display-select codes, operator codes and switch
// indices shared by quiz_round_ctrl and its helpers.
package quiz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SHOW1,
        ST_SHOW2,
        ST_SHOW3,
        ST_ANSWER,
        ST_RESULT,
        ST_DONE
    } state_e;

    localparam logic [1:0] DISP_BLANK = 2'd0;
    localparam logic [1:0] DISP_OP1   = 2'd1;
    localparam logic [1:0] DISP_OP2   = 2'd2;
    localparam logic [1:0] DISP_RES   = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_INV = 2'd3;

    localparam int         SW_PASS      = 3;
    localparam logic [3:0] SW_PASS_MASK = 4'b0001 << SW_PASS;

    // Switch pattern that answers the given operator; the invalid operator
    // has no answering switch, so nothing can match it.
    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        logic [3:0] mask;
        mask = 4'b0000;
        case (op)
            OP_ADD:  mask = 4'b0001;
            OP_SUB:  mask = 4'b0010;
            OP_MUL:  mask = 4'b0100;
            OP_INV:  mask = 4'b0000;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - loadable tick down-counter for the timed quiz states
//
// Purpose: holds the remaining ticks of a timed state.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   load       - load load_val this cycle (wins over tick)
//   load_val   - value loaded on entry to a timed state (N-1)
//   tick       - slow enable pulse
//   count      - current count
//   expire     - tick while count is zero; the owner ignores it on load cycles
module tick_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (tick && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Kept independent of load so the FSM can use it to decide the load
    // without forming a combinational loop.
    assign expire = tick & (count_q == '0);
    assign count  = count_q;

endmodule

// File: rtl/quiz_round_ctrl.sv
// rtl/quiz_round_ctrl.sv - round sequencer for the arithmetic quiz game
//
// Purpose: requests a problem, cycles the three number displays, runs the
// timed answer window, judges the answer and keeps score/round count.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   tick           - slow enable pulse from the divider
//   start          - begins a game from IDLE or DONE
//   gen_ack        - datapath has new operands and op_code
//   op_code        - operator of the current problem
//   switch         - answer buttons [0] add [1] sub [2] mul [3] pass
//   gen_req        - problem request, held until gen_ack
//   disp_sel       - shared display select
//   ans_left       - ticks left in the answer window, 0 elsewhere
//   score, round   - current score and completed rounds
//   correct, wrong - one-cycle judgement pulses
//   game_over      - high in DONE
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int SHOW_TICKS   = 10,
    parameter int ANSWER_TICKS = 30,
    parameter int NUM_ROUNDS   = 9,
    parameter int MAX_SCORE    = 9,
    parameter int CNT_W        = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             gen_ack,
    input  logic [1:0]       op_code,
    input  logic [3:0]       switch,
    output logic             gen_req,
    output logic [1:0]       disp_sel,
    output logic [CNT_W-1:0] ans_left,
    output logic [3:0]       score,
    output logic [3:0]       round,
    output logic             correct,
    output logic             wrong,
    output logic             game_over
);

    localparam logic [CNT_W-1:0] SHOW_LOAD   = CNT_W'(SHOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ANSWER_LOAD = CNT_W'(ANSWER_TICKS - 1);
    localparam logic [3:0]       MAX_SCORE_C = 4'(MAX_SCORE);
    localparam logic [3:0]       ROUNDS_C    = 4'(NUM_ROUNDS);

    state_e     state_q;
    logic [1:0] op_q;
    logic [3:0] sw_prev_q;
    logic       gen_req_q;
    logic [1:0] disp_sel_q;
    logic [3:0] score_q;
    logic [3:0] round_q;
    logic       correct_q;
    logic       wrong_q;
    logic       game_over_q;

    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic [CNT_W-1:0] timer_count;
    logic             timer_expire;

    logic [3:0] sw_rise;
    logic       any_rise;
    logic       ans_hit;
    logic       pass_hit;
    logic [3:0] score_d;
    logic [3:0] round_d;

    tick_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_load_val),
        .tick     (tick),
        .count    (timer_count),
        .expire   (timer_expire)
    );

    always_comb begin
        sw_rise  = switch & ~sw_prev_q;
        any_rise = |sw_rise;
        // Exactly one edge on the operator's switch; simultaneous edges never match.
        ans_hit  = (sw_rise == op_onehot(op_q));
        pass_hit = (sw_rise == SW_PASS_MASK);
        score_d  = (score_q < MAX_SCORE_C) ? score_q + 4'd1 : score_q;
        round_d  = round_q + 4'd1;

        // The timer loads in the same cycle the FSM enters a timed state, so
        // a tick in the first cycle of that state already counts.
        timer_load     = 1'b0;
        timer_load_val = '0;
        case (state_q)
            ST_REQ: begin
                if (gen_ack) begin
                    timer_load     = 1'b1;
                    timer_load_val = SHOW_LOAD;
                end
            end
            ST_SHOW1, ST_SHOW2: begin
                if (timer_expire) begin
                    timer_load     = 1'b1;
                    timer_load_val = SHOW_LOAD;
                end
            end
            ST_SHOW3: begin
                if (timer_expire) begin
                    timer_load     = 1'b1;
                    timer_load_val = ANSWER_LOAD;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'd0;
            sw_prev_q   <= 4'd0;
            gen_req_q   <= 1'b0;
            disp_sel_q  <= DISP_BLANK;
            score_q     <= 4'd0;
            round_q     <= 4'd0;
            correct_q   <= 1'b0;
            wrong_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            sw_prev_q <= switch;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_REQ;
                        gen_req_q <= 1'b1;
                        score_q   <= 4'd0;
                        round_q   <= 4'd0;
                    end
                end
                ST_REQ: begin
                    if (gen_ack) begin
                        op_q       <= op_code;
                        gen_req_q  <= 1'b0;
                        disp_sel_q <= DISP_OP1;
                        state_q    <= ST_SHOW1;
                    end
                end
                ST_SHOW1: begin
                    if (timer_expire) begin
                        state_q    <= ST_SHOW2;
                        disp_sel_q <= DISP_OP2;
                    end
                end
                ST_SHOW2: begin
                    if (timer_expire) begin
                        state_q    <= ST_SHOW3;
                        disp_sel_q <= DISP_RES;
                    end
                end
                ST_SHOW3: begin
                    if (timer_expire) begin
                        state_q <= ST_ANSWER;
                    end
                end
                ST_ANSWER: begin
                    // An edge on the final tick still counts as an answer.
                    if (any_rise) begin
                        state_q    <= ST_RESULT;
                        disp_sel_q <= DISP_BLANK;
                        if (ans_hit) begin
                            correct_q <= 1'b1;
                            score_q   <= score_d;
                        end else if (!pass_hit) begin
                            wrong_q <= 1'b1;
                        end
                    end else if (timer_expire) begin
                        state_q    <= ST_RESULT;
                        disp_sel_q <= DISP_BLANK;
                        wrong_q    <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (tick) begin
                        round_q <= round_d;
                        if (round_d == ROUNDS_C) begin
                            state_q     <= ST_DONE;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q   <= ST_REQ;
                            gen_req_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_REQ;
                        gen_req_q   <= 1'b1;
                        game_over_q <= 1'b0;
                        score_q     <= 4'd0;
                        round_q     <= 4'd0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ans_left  = (state_q == ST_ANSWER) ? timer_count + CNT_W'(1) : '0;
    assign gen_req   = gen_req_q;
    assign disp_sel  = disp_sel_q;
    assign score     = score_q;
    assign round     = round_q;
    assign correct   = correct_q;
    assign wrong     = wrong_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb/tb_quiz_round_ctrl.sv - directed self-checking bench for quiz_round_ctrl
module tb_quiz_round_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       start;
    logic       gen_ack;
    logic [1:0] op_code;
    logic [3:0] switch;

    logic       gen_req,   s_gen_req;
    logic [1:0] disp_sel,  s_disp_sel;
    logic [5:0] ans_left,  s_ans_left;
    logic [3:0] score,     s_score;
    logic [3:0] round,     s_round;
    logic       correct,   s_correct;
    logic       wrong,     s_wrong;
    logic       game_over, s_game_over;

    int checks = 0;
    int errors = 0;
    int exp_disp [6] = '{1, 2, 2, 3, 3, 3};

    quiz_round_ctrl #(
        .SHOW_TICKS(2), .ANSWER_TICKS(4), .NUM_ROUNDS(3), .MAX_SCORE(9), .CNT_W(6)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .gen_ack(gen_ack),
        .op_code(op_code), .switch(switch), .gen_req(gen_req), .disp_sel(disp_sel),
        .ans_left(ans_left), .score(score), .round(round), .correct(correct),
        .wrong(wrong), .game_over(game_over)
    );

    quiz_round_ctrl #(
        .SHOW_TICKS(2), .ANSWER_TICKS(4), .NUM_ROUNDS(3), .MAX_SCORE(2), .CNT_W(6)
    ) dut_sat (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .gen_ack(gen_ack),
        .op_code(op_code), .switch(switch), .gen_req(s_gen_req), .disp_sel(s_disp_sel),
        .ans_left(s_ans_left), .score(s_score), .round(s_round), .correct(s_correct),
        .wrong(s_wrong), .game_over(s_game_over)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick_cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    // From REQ: acknowledge a problem, then walk the six show ticks into ANSWER.
    task automatic to_answer(input logic [1:0] op, input logic with_tick);
        gen_ack = 1'b1;
        op_code = op;
        tick    = with_tick;
        cyc();
        gen_ack = 1'b0;
        tick    = 1'b0;
        chk("req_drop", gen_req, 0);
        chk("show1_entry", disp_sel, 1);
        for (int k = 0; k < 6; k++) begin
            tick_cyc();
            chk("show_seq", disp_sel, exp_disp[k]);
            if (k == 4) chk("not_yet_answer", ans_left, 0);
        end
        chk("ans_left_entry", ans_left, 4);
    endtask

    task automatic play_correct(input logic [1:0] op);
        to_answer(op, 1'b0);
        switch = 4'b0001 << op;
        cyc();
        chk("pc_correct", correct, 1);
        switch = 4'b0000;
        cyc();
        tick_cyc();
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; gen_ack = 1'b0;
        op_code = 2'd0; switch = 4'd0;
        cyc();
        cyc();
        chk("rst_gen_req", gen_req, 0);
        chk("rst_disp", disp_sel, 0);
        chk("rst_ans_left", ans_left, 0);
        chk("rst_score", score, 0);
        chk("rst_round", round, 0);
        chk("rst_correct", correct, 0);
        chk("rst_wrong", wrong, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_sat_all", {s_gen_req, s_disp_sel, s_ans_left, s_score, s_round,
                            s_correct, s_wrong, s_game_over}, 0);
        reset = 1'b0;

        // Game 1: correct, wrong bit, multiple edges.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("g1_req", gen_req, 1);
        cyc();
        chk("g1_req_held", gen_req, 1);
        chk("g1_req_disp", disp_sel, 0);
        to_answer(2'd1, 1'b0);
        switch = 4'b0010;
        cyc();
        chk("r1_correct", correct, 1);
        chk("r1_wrong", wrong, 0);
        chk("r1_score", score, 1);
        chk("r1_disp_blank", disp_sel, 0);
        chk("r1_ans_left", ans_left, 0);
        switch = 4'b0000;
        cyc();
        chk("r1_pulse_end", correct, 0);
        chk("r1_round_wait", round, 0);
        tick_cyc();
        chk("r1_round", round, 1);
        chk("r1_next_req", gen_req, 1);

        to_answer(2'd2, 1'b0);
        switch = 4'b0001;
        cyc();
        chk("r2_wrong", wrong, 1);
        chk("r2_no_correct", correct, 0);
        chk("r2_score", score, 1);
        switch = 4'b0000;
        cyc();
        tick_cyc();
        chk("r2_round", round, 2);

        to_answer(2'd2, 1'b0);
        switch = 4'b0101;
        cyc();
        chk("r3_multi_wrong", wrong, 1);
        chk("r3_score", score, 1);
        switch = 4'b0000;
        cyc();
        tick_cyc();
        chk("g1_game_over", game_over, 1);
        chk("g1_round", round, 3);
        chk("g1_score", score, 1);
        chk("g1_no_req", gen_req, 0);

        // Game 2: timeout, edge on final tick, held switch.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("g2_score_clr", score, 0);
        chk("g2_round_clr", round, 0);
        chk("g2_go_clr", game_over, 0);
        chk("g2_req", gen_req, 1);
        to_answer(2'd0, 1'b0);
        tick_cyc();
        chk("to_ans3", ans_left, 3);
        tick_cyc();
        chk("to_ans2", ans_left, 2);
        tick_cyc();
        chk("to_ans1", ans_left, 1);
        chk("to_no_wrong_yet", wrong, 0);
        tick_cyc();
        chk("to_wrong", wrong, 1);
        chk("to_ans_left0", ans_left, 0);
        tick_cyc();
        chk("to_round", round, 1);

        to_answer(2'd0, 1'b1);
        tick_cyc();
        tick_cyc();
        tick_cyc();
        chk("fe_ans1", ans_left, 1);
        switch = 4'b0001;
        tick   = 1'b1;
        cyc();
        switch = 4'b0000;
        tick   = 1'b0;
        chk("fe_correct", correct, 1);
        chk("fe_no_wrong", wrong, 0);
        chk("fe_score", score, 1);
        cyc();
        tick_cyc();
        chk("fe_round", round, 2);

        switch = 4'b0010;
        to_answer(2'd1, 1'b0);
        cyc();
        chk("held_no_correct", correct, 0);
        chk("held_no_wrong", wrong, 0);
        chk("held_still_answer", ans_left, 4);
        switch = 4'b0000;
        cyc();
        switch = 4'b0010;
        cyc();
        chk("repress_correct", correct, 1);
        chk("repress_score", score, 2);
        chk("repress_sat_score", s_score, 2);
        switch = 4'b0000;
        cyc();
        tick_cyc();
        chk("g2_game_over", game_over, 1);
        chk("g2_score", score, 2);

        // Game 3: pass, then reset in ANSWER and REQ.
        start = 1'b1;
        cyc();
        start = 1'b0;
        to_answer(2'd1, 1'b0);
        switch = 4'b1000;
        cyc();
        chk("pass_no_correct", correct, 0);
        chk("pass_no_wrong", wrong, 0);
        chk("pass_disp", disp_sel, 0);
        chk("pass_score", score, 0);
        switch = 4'b0000;
        tick_cyc();
        chk("pass_round", round, 1);
        chk("pass_req", gen_req, 1);

        to_answer(2'd0, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rstA_disp", disp_sel, 0);
        chk("rstA_ans_left", ans_left, 0);
        chk("rstA_round", round, 0);
        chk("rstA_gen_req", gen_req, 0);

        gen_ack = 1'b1;
        op_code = 2'd2;
        cyc();
        gen_ack = 1'b0;
        chk("idle_ack_req", gen_req, 0);
        chk("idle_ack_disp", disp_sel, 0);
        tick_cyc();
        chk("idle_tick_disp", disp_sel, 0);

        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("rstR_pre", gen_req, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rstR_gen_req", gen_req, 0);
        cyc();
        chk("rstR_idle", gen_req, 0);

        // Game 4: three correct rounds and saturation.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("g4_req", gen_req, 1);
        play_correct(2'd0);
        play_correct(2'd1);
        play_correct(2'd2);
        chk("g4_game_over", game_over, 1);
        chk("g4_score", score, 3);
        chk("g4_round", round, 3);
        chk("g4_sat_score", s_score, 2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("g4_restart_score", score, 0);
        chk("g4_restart_round", round, 0);
        chk("g4_restart_req", gen_req, 1);
        chk("g4_restart_go", game_over, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
Round sequencer for the arithmetic quiz game.
- Requests a fresh operand/operator set from the quiz datapath.
- Time-multiplexes the three number displays (operand 1, operand 2, result) onto one shared display select.
- Opens a timed answer window on the operator switches, judges the answer and keeps score and round count until game over.
- Sits between the slow tick divider, the switch inputs and the quiz datapath/7-seg decoders.

Parameters:
SHOW_TICKS, 10, ticks each number stays displayed (min 1)
ANSWER_TICKS, 30, ticks in answer window (min 1, < 2^CNT_W)
NUM_ROUNDS, 9, rounds per game (1..15)
MAX_SCORE, 9, score saturation value (single 7-seg digit)
CNT_W, 6, width of tick down-counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
tick  in  1  one-cycle enable pulse from frequency divider
start  in  1  level; begins game from IDLE or DONE
gen_ack  in  1  datapath: new operands and op_code valid this cycle
op_code  in  2  operator of current problem: 0 add, 1 sub, 2 mul, 3 invalid
switch  in  4  answer buttons: [0] add, [1] sub, [2] mul, [3] pass
gen_req  out  1  request new problem; held until gen_ack
disp_sel  out  2  0 blank, 1 operand1, 2 operand2, 3 result
ans_left  out  CNT_W  ticks remaining in answer window, 0 outside ANSWER
score  out  4  current score
round  out  4  completed rounds
correct  out  1  one-cycle pulse, correct answer
wrong  out  1  one-cycle pulse, wrong answer or timeout
game_over  out  1  high in DONE

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset (any state, mid-round included) -> IDLE.
- Reset values: all outputs 0, counters 0, latched op 0, switch history 0.
- FSM states: IDLE, REQ, SHOW1, SHOW2, SHOW3, ANSWER, RESULT, DONE.
- IDLE: start -> REQ. Score and round are cleared on that transition.
- REQ: gen_req=1. gen_ack -> latch op_code into op_q, go to SHOW1. gen_req drops the same cycle as the transition (registered; low from next cycle). No timeout.
- gen_ack outside REQ is ignored.
- Timed states: the down-counter loads on entry with (N-1), where N is SHOW_TICKS or ANSWER_TICKS.
  - On each tick: count==0 -> exit, else decrement.
  - A state therefore lasts exactly N ticks after entry.
- SHOW1/SHOW2/SHOW3: disp_sel = 1/2/3. Switches are ignored. Each state exits to the next; SHOW3 -> ANSWER.
- ANSWER:
  - disp_sel=3. ans_left = counter+1 (counts N..1).
  - Switches are rising-edge detected: a registered copy of the previous switch value is kept every cycle in all states, so a button held on entry does not count.
  - First cycle with any rising edge decides the round:
    - exactly one edge on bit[op_q] with op_q<3 -> correct;
    - edge on bit[3] alone -> pass (neither pulse);
    - anything else (wrong bit, multiple simultaneous edges, or op_q==3 with a non-pass edge) -> wrong.
  - Decision -> RESULT next cycle. correct/wrong pulse in that same cycle.
  - Timeout (tick with count==0 and no edge) -> wrong pulse, -> RESULT.
  - An edge in the same cycle as the final tick takes priority over the timeout.
- correct: score <= min(score+1, MAX_SCORE).
- RESULT:
  - disp_sel=0. Waits for the next tick.
  - On that tick round increments. If the new round == NUM_ROUNDS -> DONE, else -> REQ.
- DONE: game_over=1, disp_sel=0. score and round hold. start -> REQ, clearing score and round.
- start is ignored in all other states.
- tick and gen_ack arriving in the same cycle in REQ: ack is handled; that tick is not counted toward SHOW1.

Decomposition:
- Shared package quiz_pkg:
  - state encoding (3-bit enum);
  - DISP_BLANK/OP1/OP2/RES constants;
  - OP_ADD/OP_SUB/OP_MUL/OP_INV codes;
  - switch index constants SW_PASS=3.
- One sub-module: tick_timer.
  - Inputs: load, load_val, tick.
  - Outputs: count, expire pulse.
  - Reused by the SHOW and ANSWER states.
- Edge detection and judging stay inline.

Test Plan:
(Bench parameters: SHOW_TICKS=2, ANSWER_TICKS=4, NUM_ROUNDS=3.)
1. reset, start, gen_ack with op_code=1 -> gen_req high until ack. disp_sel 1,1,2,2,3,3 on successive ticks. ans_left 4. switch[1] pulse -> correct pulse, score=1, round=1 after next tick.
2. op_code=2, switch[0] rising -> wrong pulse, score unchanged. Also switch[0]|switch[2] rising in the same cycle -> wrong.
3. No switch in ANSWER -> ans_left 4,3,2,1, then wrong pulse on the 4th tick. Edge on the same cycle as the 4th tick -> judged as an answer, not a timeout.
4. switch[1] held from SHOW1 into ANSWER -> no decision. Release and repress -> judged. switch[3] -> no pulses, round still increments.
5. Three correct rounds -> game_over=1, score=3, round=3. start -> score=0, round=0, gen_req=1. With MAX_SCORE=2: score saturates at 2.
6. reset asserted in ANSWER and in REQ -> next cycle IDLE, all outputs 0. gen_ack pulsed while in IDLE -> ignored.
